// File: rtl/mux_scan_ctrl_pkg.sv
// Shared definitions for the 4:1 mux scan sequencer: state codes, channel
// count and select width.
package mux_scan_ctrl_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/scan_dwell_timer.sv
// Reloadable down-counter that times the settle window on each mux channel.
// zero is high once the loaded count has run out; hold freezes the count.
module scan_dwell_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             hold,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;

  // Count down to zero and park there; a load restarts the window.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (!hold) begin
      if (load) begin
        cnt_q <= load_val;
      end else if (cnt_q != '0) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/mux_scan_ctrl.sv
// Sequencer for the 4:1 mux stage: steps the select lines through channels
// 0..3, waits DWELL clocks on each for the mux output to settle, samples it,
// and presents the four samples as one word with a valid/done pulse.
// Build option: define MUX_SCAN_CONT_EN for continuous scanning (DONE loops
// straight back to channel 0; only rst returns the block to IDLE).
module mux_scan_ctrl #(
  parameter int DWELL = 2,
  parameter int CNT_W = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       hold,
  input  logic       mux_out,
  output logic       s0,
  output logic       s1,
  output logic [3:0] data,
  output logic       valid,
  output logic       busy,
  output logic       done
);

  import mux_scan_ctrl_pkg::*;

  state_t           state_q, state_d;
  logic [SEL_W-1:0] sel_q;
  logic [2:0]       shadow_q;
  logic [3:0]       data_q;

  logic tmr_load, tmr_hold, tmr_zero;
  logic sel_clr, sel_inc, cap, cap_last;

  // Hold has no meaning in IDLE, so a start there is always accepted.
  assign tmr_hold = hold && (state_q != ST_IDLE);

  scan_dwell_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .hold     (tmr_hold),
    .load_val (CNT_W'(DWELL - 1)),
    .zero     (tmr_zero)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and per-state datapath strobes.
  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    sel_clr  = 1'b0;
    sel_inc  = 1'b0;
    cap      = 1'b0;
    cap_last = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_SETTLE;
          tmr_load = 1'b1;
          sel_clr  = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (!hold && tmr_zero) begin
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (!hold) begin
          cap = 1'b1;
          if (sel_q == SEL_W'(NUM_CH - 1)) begin
            cap_last = 1'b1;
            state_d  = ST_DONE;
          end else begin
            sel_inc  = 1'b1;
            tmr_load = 1'b1;
            state_d  = ST_SETTLE;
          end
        end
      end
      ST_DONE: begin
        if (!hold) begin
`ifdef MUX_SCAN_CONT_EN
          state_d  = ST_SETTLE;
          tmr_load = 1'b1;
          sel_clr  = 1'b1;
`else
          state_d  = ST_IDLE;
`endif
        end
      end
    endcase
  end

  // Select, partial-sample and output word registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q    <= '0;
      shadow_q <= '0;
      data_q   <= '0;
    end else begin
      if (sel_clr) begin
        sel_q <= '0;
      end else if (sel_inc) begin
        sel_q <= sel_q + SEL_W'(1);
      end
      if (cap) begin
        for (int i = 0; i < NUM_CH - 1; i++) begin
          if (sel_q == SEL_W'(i)) begin
            shadow_q[i] <= mux_out;
          end
        end
      end
      if (cap_last) begin
        data_q <= {mux_out, shadow_q};
      end
    end
  end

  assign s1    = sel_q[1];
  assign s0    = sel_q[0];
  assign data  = data_q;
  assign busy  = (state_q != ST_IDLE);
  assign valid = (state_q == ST_DONE) && !hold;
  assign done  = valid;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: one instance with DWELL=2, one with DWELL=1, an
// abstract timeline model per instance and directed scan scenarios.
module tb_mux_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst [2];
  logic       start [2];
  logic       hold [2];
  logic [3:0] pat [2];
  logic       mux_out [2];
  logic       s0_o [2];
  logic       s1_o [2];
  logic [3:0] data_o [2];
  logic       valid_o [2];
  logic       busy_o [2];
  logic       done_o [2];

  int vecs = 0;
  int errs = 0;
  logic cmp_en = 1'b0;

  always #5 clk = ~clk;

  // Emulated combinational 4:1 mux: channel n presents pattern bit n.
  assign mux_out[0] = pat[0][{s1_o[0], s0_o[0]}];
  assign mux_out[1] = pat[1][{s1_o[1], s0_o[1]}];

  mux_scan_ctrl #(.DWELL(2), .CNT_W(8)) u_d2 (
    .clk(clk), .rst(rst[0]), .start(start[0]), .hold(hold[0]),
    .mux_out(mux_out[0]), .s0(s0_o[0]), .s1(s1_o[0]), .data(data_o[0]),
    .valid(valid_o[0]), .busy(busy_o[0]), .done(done_o[0]));

  mux_scan_ctrl #(.DWELL(1), .CNT_W(8)) u_d1 (
    .clk(clk), .rst(rst[1]), .start(start[1]), .hold(hold[1]),
    .mux_out(mux_out[1]), .s0(s0_o[1]), .s1(s1_o[1]), .data(data_o[1]),
    .valid(valid_o[1]), .busy(busy_o[1]), .done(done_o[1]));

  task automatic chk(input string name, input int act, input int exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: a scan is a run of non-held cycles p = 0 .. 4*(D+1). Channel c owns
  // cycles c*(D+1) .. c*(D+1)+D, sampled at the end of its last one; cycle
  // 4*(D+1) is the valid/done cycle.
  logic       m_act [2];
  int         m_p [2];
  int         m_sel [2];
  logic [3:0] m_part [2];
  logic [3:0] m_data [2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      automatic int d = (i == 0) ? 2 : 1;
      automatic int len = 4 * (d + 1);
      if (rst[i]) begin
        m_act[i] = 1'b0; m_p[i] = 0; m_sel[i] = 0; m_part[i] = 4'b0; m_data[i] = 4'b0;
      end else if (!m_act[i]) begin
        if (start[i]) begin
          m_act[i] = 1'b1; m_p[i] = 0; m_sel[i] = 0;
        end
      end else if (!hold[i]) begin
        if (m_p[i] == len) begin
`ifdef MUX_SCAN_CONT_EN
          m_p[i] = 0; m_sel[i] = 0;
`else
          m_act[i] = 1'b0;
`endif
        end else begin
          if (m_p[i] % (d + 1) == d) begin
            automatic int ch = m_p[i] / (d + 1);
            m_part[i][ch] = pat[i][ch];
            if (ch == 3) m_data[i] = m_part[i];
          end
          m_p[i]++;
          if (m_p[i] < len) m_sel[i] = m_p[i] / (d + 1);
        end
      end
    end
  end

  // Compare every DUT output against the model on each falling edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int i = 0; i < 2; i++) begin
        automatic int len = 4 * (((i == 0) ? 2 : 1) + 1);
        automatic logic ev = m_act[i] && (m_p[i] == len) && !hold[i];
        chk($sformatf("sel%0d", i), int'({s1_o[i], s0_o[i]}), m_sel[i]);
        chk($sformatf("busy%0d", i), int'(busy_o[i]), int'(m_act[i]));
        chk($sformatf("valid%0d", i), int'(valid_o[i]), int'(ev));
        chk($sformatf("done%0d", i), int'(done_o[i]), int'(ev));
        chk($sformatf("data%0d", i), int'(data_o[i]), int'(m_data[i]));
      end
    end
  end

  task automatic do_reset(input int i);
    @(posedge clk); #1 rst[i] = 1'b1;
    @(posedge clk); #1 rst[i] = 1'b0;
    chk("rst_sel", int'({s1_o[i], s0_o[i]}), 0);
    chk("rst_busy", int'(busy_o[i]), 0);
    chk("rst_valid", int'(valid_o[i]), 0);
    chk("rst_data", int'(data_o[i]), 0);
  endtask

  // One scan: start pulse, optional hold window (set after edge hs for hl
  // edges), then latency, data and the busy level one clock after valid.
  task automatic run_scan(input int i, input logic [3:0] p, input logic [3:0] exp_data,
                          input int exp_lat, input int hs, input int hl, input string name);
    int n;
    bit seen;
    pat[i] = p;
    @(posedge clk); #1 start[i] = 1'b1;
    @(posedge clk); #1 start[i] = 1'b0;
    n = 0; seen = 0;
    while (!seen && n < 100) begin
      @(posedge clk); #1;
      n++;
      if (valid_o[i]) seen = 1;
      else if (hl > 0 && n == hs) hold[i] = 1'b1;
      else if (hl > 0 && n == hs + hl) hold[i] = 1'b0;
    end
    hold[i] = 1'b0;
    chk({name, "_latency"}, seen ? n : -1, exp_lat);
    chk({name, "_data"}, int'(data_o[i]), int'(exp_data));
    @(posedge clk); #1;
`ifdef MUX_SCAN_CONT_EN
    chk({name, "_busy_after"}, int'(busy_o[i]), 1);
`else
    chk({name, "_busy_after"}, int'(busy_o[i]), 0);
`endif
  endtask

  initial begin
    int vcount, vfirst, vsecond;
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; start[i] = 1'b0; hold[i] = 1'b0; pat[i] = 4'b0;
    end
    @(posedge clk); #1;
    cmp_en = 1'b1;
    rst[0] = 1'b0; rst[1] = 1'b0;

    // 1: all channels high
    do_reset(0);
    run_scan(0, 4'b1111, 4'b1111, 12, 0, 0, "all_ones");
    // 2: only channels 1 and 2 high
    do_reset(0);
    run_scan(0, 4'b0110, 4'b0110, 12, 0, 0, "mid_chans");
    // 3: five-clock hold on channel 2
    do_reset(0);
    run_scan(0, 4'b1010, 4'b1010, 17, 6, 5, "hold_ch2");

    // 4: reset during channel 1, then a clean scan
    do_reset(0);
    pat[0] = 4'b1111;
    @(posedge clk); #1 start[0] = 1'b1;
    @(posedge clk); #1 start[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst[0] = 1'b1;
    @(posedge clk); #1 rst[0] = 1'b0;
    chk("abort_sel", int'({s1_o[0], s0_o[0]}), 0);
    chk("abort_busy", int'(busy_o[0]), 0);
    chk("abort_data", int'(data_o[0]), 0);
    run_scan(0, 4'b0011, 4'b0011, 12, 0, 0, "after_abort");

    // 5: start held high for 30 clocks
    do_reset(0);
    pat[0] = 4'b0101;
    vcount = 0; vfirst = -1; vsecond = -1;
    @(posedge clk); #1 start[0] = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk); #1;
      if (valid_o[0]) begin
        vcount++;
        if (vfirst < 0) vfirst = n;
        else if (vsecond < 0) vsecond = n;
      end
    end
    start[0] = 1'b0;
    chk("start_high_count", vcount, 2);
    chk("start_high_first", vfirst, 12);
`ifdef MUX_SCAN_CONT_EN
    chk("start_high_second", vsecond, 25);
`else
    chk("start_high_second", vsecond, 26);
`endif
    chk("start_high_data", int'(data_o[0]), 5);
    do_reset(0);

    // 6: DWELL=1 instance
    do_reset(1);
    run_scan(1, 4'b1001, 4'b1001, 8, 0, 0, "dwell1");
    do_reset(1);
    run_scan(1, 4'b0110, 4'b0110, 11, 3, 3, "dwell1_hold");

    repeat (3) @(posedge clk);
    #1 cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
